dart_stats_drain: RTL and testbench
===================================

Name: dart_stats_drain

Overview:
- Sits between the simulator's stats shift chain and the UART port's transmit side.
- On a start pulse from the control unit it frames and streams the simulator statistics to the PC:
  - one header word;
  - NUM_WORDS data words pulled from the stats chain;
  - optionally, a checksum word.
- Paces itself on the UART port's tx_valid/tx_ack handshake and drives stats_shift to advance the chain.

Parameters:
- WIDTH, 16, word width of stats chain and tx path (fixed 16 in this design; header layout assumes 16)
- NUM_WORDS, 64, number of stats words drained per dump; legal range 1..256
- HEADER_TAG, 8'hDA, upper byte of header word

Ports:
- clock  in  1  system clock (50 MHz domain)
- reset  in  1  reset; asynchronous and active-low
- enable  in  1  global enable (DCM locked); when low, all state holds
- start  in  1  one-cycle request to begin a dump
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse when the final word is acknowledged
- error  out  1  sticky protocol error
- stats_word  in  WIDTH  current head of the simulator stats chain
- stats_shift  out  1  one-cycle pulse advancing the chain by one word
- tx_word  out  WIDTH  word offered to the UART port
- tx_valid  out  1  tx_word valid; held until tx_ack
- tx_ack  in  1  one-cycle accept from the UART port

Behaviour:
- Reset (reset low, async): state IDLE; every output 0; counter 0; checksum 0; error cleared.
- enable low: no state, counter or output register changes. Pulses in flight are not repeated. start and tx_ack are ignored that cycle.
- States: IDLE, HEADER, LOAD, SEND, SHIFT, CSUM, DONE.
- IDLE:
  - start=1 -> HEADER next cycle.
  - Registered: tx_word={HEADER_TAG, NUM_WORDS-1 [7:0]}, tx_valid=1, busy=1, counter=0, checksum=0.
  - Latency: start at cycle 0 -> tx_valid at cycle 1.
- HEADER: hold until tx_ack; then tx_valid=0 -> LOAD. No shift follows the header; the chain head is already word 0.
- LOAD: register tx_word=stats_word, tx_valid=1, checksum^=stats_word -> SEND.
- SEND: hold tx_word/tx_valid until tx_ack; then tx_valid=0, stats_shift=1 for the next cycle -> SHIFT.
- SHIFT:
  - Executes the shift.
  - If counter==NUM_WORDS-1 -> CSUM (feature on) or DONE; else counter+1 -> LOAD.
  - Exactly NUM_WORDS shifts occur per dump, including after the last word.
- CSUM: present checksum with tx_valid=1; on tx_ack -> DONE.
- DONE: done=1 for one cycle, busy=0 -> IDLE.
- Per data word: ack at cycle k -> stats_shift at k+1 -> tx_valid at k+3 with the new word.
- tx_ack while tx_valid=0: ignored and sets error.
- start while busy: ignored and sets error.
- start coincident with done: ignored, no error; start must arrive in IDLE.
- Counter width $clog2(NUM_WORDS), minimum 1 bit; compare against NUM_WORDS-1, no wrap.
- Checksum: WIDTH-bit XOR of all data words; header excluded.
- reset asserted mid-dump: immediate return to IDLE, outputs 0. The chain is not rewound; the control unit must pulse sim_reset or re-dump.

Optional Feature:
- Macro: DART_STATS_CHECKSUM_EN.
- Defined: the CSUM state exists and the checksum word is sent after the last data word. Header bit 7 of the lower byte is unchanged; the PC learns of the checksum from its build.
- Undefined: the CSUM state and checksum register are not synthesised; SHIFT goes to DONE. Transfer length is NUM_WORDS+1 words.

Decomposition:
- Shared package dart_stats_pkg:
  - state enum type;
  - HEADER_TAG default;
  - WIDTH default;
  - header-construction function.
- No sub-module: single FSM with counter and checksum register. A separate module would only add handshake wiring.

Test Plan:
- NUM_WORDS=4, chain 16'h0001..0004, tx_ack 2 cycles after each tx_valid -> tx sequence DA03,0001,0002,0003,0004; 4 stats_shift pulses; done once; busy low after.
- Same with DART_STATS_CHECKSUM_EN -> fifth word 16'h0004 (1^2^3^4); done only after its ack.
- enable dropped for 5 cycles while in SEND -> tx_word/tx_valid held; no extra shift; sequence completes unchanged.
- start pulsed during SEND -> error=1 and stays 1; transfer continues normally.
- Spurious tx_ack in IDLE -> error=1, no tx_valid, no shift.
- reset low during second data word -> all outputs 0 same cycle. New start -> header DA03 again, error 0.

Source files
------------

// File: rtl/dart_stats_pkg.sv
// dart_stats_pkg: shared definitions for the stats drain.
//   dart_state_e     - drain FSM state type (fixed legacy encodings)
//   DART_WIDTH       - default word width of stats chain and tx path
//   DART_HEADER_TAG  - default upper byte of the header word
//   make_header()    - builds {tag, NUM_WORDS-1} header word
package dart_stats_pkg;

   localparam int unsigned DART_WIDTH      = 16;
   localparam logic [7:0]  DART_HEADER_TAG = 8'hDA;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HEADER = 3'd1,
      ST_LOAD   = 3'd2,
      ST_SEND   = 3'd3,
      ST_SHIFT  = 3'd4,
      ST_CSUM   = 3'd5,
      ST_DONE   = 3'd6
   } dart_state_e;

   // Lower byte carries the word count minus one so 256 words still fit.
   function automatic logic [15:0] make_header(input logic [7:0] tag,
                                               input int unsigned num_words);
      logic [7:0] cnt_m1;
      cnt_m1 = 8'(num_words - 1);
      return {tag, cnt_m1};
   endfunction

endpackage

// File: rtl/dart_stats_drain_if.sv
// dart_stats_drain_if: word handshake between the stats drain and the UART
// transmit side.
//   tx_word  - word offered to the UART port
//   tx_valid - tx_word valid, held until tx_ack
//   tx_ack   - one-cycle accept from the UART port
// master: the drain (drives word/valid); slave: the UART port.
interface dart_stats_drain_if
   import dart_stats_pkg::*;
#(
   parameter int unsigned WIDTH = DART_WIDTH
) ();

   logic [WIDTH-1:0] tx_word;
   logic             tx_valid;
   logic             tx_ack;

   modport master (
      output tx_word,
      output tx_valid,
      input  tx_ack
   );

   modport slave (
      input  tx_word,
      input  tx_valid,
      output tx_ack
   );

endinterface

// File: rtl/dart_stats_drain.sv
// dart_stats_drain: frames and streams simulator statistics to the UART port.
// On start it sends a header word, then NUM_WORDS words pulled from the stats
// shift chain (one stats_shift pulse per word, including after the last),
// and, when DART_STATS_CHECKSUM_EN is defined, an XOR checksum word.
// Ports:
//   clock       - system clock
//   reset       - asynchronous active-low reset
//   enable      - global enable; when low all state holds
//   start       - one-cycle dump request (accepted only in IDLE)
//   busy        - high from the cycle after accepted start until done
//   done        - one-cycle pulse after the final word is acknowledged
//   error       - sticky protocol error (start while busy, ack without valid)
//   stats_word  - current head of the stats chain
//   stats_shift - one-cycle pulse advancing the chain
//   tx          - master side of dart_stats_drain_if (tx_word/tx_valid/tx_ack)
// Optional feature macro: DART_STATS_CHECKSUM_EN.
module dart_stats_drain
   import dart_stats_pkg::*;
#(
   parameter int unsigned WIDTH      = DART_WIDTH,
   parameter int unsigned NUM_WORDS  = 64,
   parameter logic [7:0]  HEADER_TAG = DART_HEADER_TAG
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       enable,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic                       error,
   input  logic [WIDTH-1:0]           stats_word,
   output logic                       stats_shift,
   dart_stats_drain_if.master         tx
);

   localparam int unsigned CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [CW-1:0] LAST = CW'(NUM_WORDS - 1);

   dart_state_e      state_q, state_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic [WIDTH-1:0] word_q,  word_d;
   logic             valid_q, valid_d;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;
   logic             err_q,   err_d;
   logic             shift_q, shift_d;
`ifdef DART_STATS_CHECKSUM_EN
   logic [WIDTH-1:0] csum_q,  csum_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      shift_d = 1'b0;
      err_d   = err_q;
`ifdef DART_STATS_CHECKSUM_EN
      csum_d  = csum_q;
`endif

      // busy is low in IDLE and DONE, so a start coincident with done is
      // silently dropped rather than flagged.
      if (tx.tx_ack && !valid_q) err_d = 1'b1;
      if (start && busy_q)       err_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               word_d  = WIDTH'(make_header(HEADER_TAG, NUM_WORDS));
               valid_d = 1'b1;
               busy_d  = 1'b1;
               cnt_d   = '0;
`ifdef DART_STATS_CHECKSUM_EN
               csum_d  = '0;
`endif
               state_d = ST_HEADER;
            end
         end
         ST_HEADER: begin
            // Chain head is already word 0, so no shift after the header.
            if (tx.tx_ack) begin
               valid_d = 1'b0;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            word_d  = stats_word;
            valid_d = 1'b1;
`ifdef DART_STATS_CHECKSUM_EN
            csum_d  = csum_q ^ stats_word;
`endif
            state_d = ST_SEND;
         end
         ST_SEND: begin
            if (tx.tx_ack) begin
               valid_d = 1'b0;
               shift_d = 1'b1;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (cnt_q == LAST) begin
`ifdef DART_STATS_CHECKSUM_EN
               word_d  = csum_q;
               valid_d = 1'b1;
               state_d = ST_CSUM;
`else
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_DONE;
`endif
            end else begin
               cnt_d   = cnt_q + 1'b1;
               state_d = ST_LOAD;
            end
         end
`ifdef DART_STATS_CHECKSUM_EN
         ST_CSUM: begin
            if (tx.tx_ack) begin
               valid_d = 1'b0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_DONE;
            end
         end
`endif
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         shift_q <= 1'b0;
`ifdef DART_STATS_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else if (enable) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         shift_q <= shift_d;
`ifdef DART_STATS_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end else begin
         // Everything holds, but pulses already shown for a cycle are
         // dropped so the chain shifts once and done fires once.
         shift_q <= 1'b0;
         done_q  <= 1'b0;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign error       = err_q;
   assign stats_shift = shift_q;
   assign tx.tx_word  = word_q;
   assign tx.tx_valid = valid_q;

endmodule

// File: tb/tb_dart_stats_drain.sv
module tb_dart_stats_drain;

   localparam int unsigned NW = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic        start = 1'b0;
   logic        busy, done, error, stats_shift;
   logic [15:0] stats_word;

   dart_stats_drain_if #(.WIDTH(16)) tx_if ();

   dart_stats_drain #(
      .WIDTH      (16),
      .NUM_WORDS  (NW),
      .HEADER_TAG (8'hDA)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .stats_word  (stats_word),
      .stats_shift (stats_shift),
      .tx          (tx_if.master)
   );

   always #5 clock = ~clock;

   // Stats chain model: a ring of words whose head advances on stats_shift.
   logic [15:0] chain [256];
   logic [7:0]  ptr = '0;
   assign stats_word = chain[ptr];
   always @(posedge clock) if (stats_shift) ptr <= ptr + 8'd1;

   int n_cmp = 0;
   int n_mis = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_zero(input string pfx);
      chk({pfx, "_busy"},  32'(busy), 0);
      chk({pfx, "_done"},  32'(done), 0);
      chk({pfx, "_err"},   32'(error), 0);
      chk({pfx, "_shift"}, 32'(stats_shift), 0);
      chk({pfx, "_valid"}, 32'(tx_if.tx_valid), 0);
      chk({pfx, "_word"},  32'(tx_if.tx_word), 0);
   endtask

   // mode: 0 normal, 1 enable drop in SEND, 2 start while busy,
   //       3 start coincident with done, 4 reset during second data word
   task automatic run_dump(input int mode, input int dlo, input int dhi,
                           input bit rnd_en, input bit exp_err);
      logic [15:0] exp[$];
      logic [15:0] rx[$];
      logic [15:0] x, w, held;
      logic [7:0]  base;
      int shifts, dones, waitc, hs;
      bit done_seen, aborted, dropped, injected;
      shifts = 0; dones = 0; hs = 0;
      done_seen = 0; aborted = 0; dropped = 0; injected = 0;
      waitc = $urandom_range(dlo, dhi);

      base = ptr;
      x = '0;
      exp.push_back({8'hDA, 8'(NW - 1)});
      for (int i = 0; i < int'(NW); i++) begin
         w = chain[8'(int'(base) + i)];
         exp.push_back(w);
         x ^= w;
      end
`ifdef DART_STATS_CHECKSUM_EN
      exp.push_back(x);
`endif

      @(negedge clock);
      enable = 1'b1; start = 1'b1; tx_if.tx_ack = 1'b0;
      @(negedge clock);
      start = 1'b0;
      chk("lat_valid", 32'(tx_if.tx_valid), 1);
      chk("lat_busy",  32'(busy), 1);

      for (int cyc = 0; cyc < 2000 && !done_seen && !aborted; cyc++) begin
         tx_if.tx_ack = 1'b0;
         start = 1'b0;
         if (stats_shift) shifts++;
         if (done) begin
            dones++;
            done_seen = 1'b1;
            enable = 1'b1;
         end else begin
            enable = rnd_en ? ($urandom_range(0, 7) != 0) : 1'b1;
            if (mode == 1 && !dropped && rx.size() == 2 && tx_if.tx_valid) begin
               held = tx_if.tx_word;
               enable = 1'b0;
               repeat (5) begin
                  @(negedge clock);
                  if (stats_shift) hs++;
               end
               chk("hold_shift", 32'(hs), 0);
               chk("hold_word",  32'(tx_if.tx_word), 32'(held));
               chk("hold_valid", 32'(tx_if.tx_valid), 1);
               enable = 1'b1;
               dropped = 1'b1;
            end
            if (mode == 2 && !injected && rx.size() == 2 && tx_if.tx_valid) begin
               start = 1'b1;
               injected = 1'b1;
            end
            if (mode == 4 && rx.size() == 2 && tx_if.tx_valid) begin
               #2 reset = 1'b0;
               #1 chk_zero("midrst");
               aborted = 1'b1;
            end
            if (!aborted) begin
               if (enable && tx_if.tx_valid) begin
                  if (waitc == 0) begin
                     tx_if.tx_ack = 1'b1;
                     rx.push_back(tx_if.tx_word);
                     waitc = $urandom_range(dlo, dhi);
                  end else begin
                     waitc--;
                  end
               end
               @(negedge clock);
            end
         end
      end

      if (aborted) begin
         @(negedge clock);
         reset = 1'b1;
         @(negedge clock);
         chk("rst_err", 32'(error), 0);
         return;
      end

      chk("done_seen", 32'(done_seen), 1);
      if (mode == 3) start = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         start = 1'b0;
         if (stats_shift) shifts++;
         if (done) dones++;
      end
      if (mode == 3) begin
         chk("sd_busy",  32'(busy), 0);
         chk("sd_valid", 32'(tx_if.tx_valid), 0);
      end

      chk("n_words", 32'(rx.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size(); i++)
         chk($sformatf("word%0d", i), (i < rx.size()) ? 32'(rx[i]) : 32'hxxxx_xxxx, 32'(exp[i]));
      chk("shifts",    32'(shifts), NW);
      chk("dones",     32'(dones), 1);
      chk("busy_end",  32'(busy), 0);
      chk("valid_end", 32'(tx_if.tx_valid), 0);
      chk("error",     32'(error), 32'(exp_err));
   endtask

   initial begin
      int sh;
      for (int i = 0; i < 256; i++)
         chain[i] = (i < int'(NW)) ? 16'(i + 1) : 16'($urandom);
      tx_if.tx_ack = 1'b0;
      repeat (3) @(negedge clock);
      chk_zero("rst");
      reset = 1'b1;
      enable = 1'b1;
      @(negedge clock);

      run_dump(0, 2, 2, 0, 0);
      repeat (4) run_dump(0, 0, 3, 1, 0);
      run_dump(3, 0, 2, 0, 0);
      run_dump(1, 1, 3, 0, 0);
      run_dump(2, 1, 3, 0, 1);

      // Clear sticky error, then a spurious ack in IDLE.
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("clr_err", 32'(error), 0);
      tx_if.tx_ack = 1'b1;
      sh = 0;
      @(negedge clock);
      tx_if.tx_ack = 1'b0;
      chk("sp_err",   32'(error), 1);
      chk("sp_valid", 32'(tx_if.tx_valid), 0);
      repeat (3) begin
         @(negedge clock);
         if (stats_shift) sh++;
      end
      chk("sp_shift", 32'(sh), 0);
      chk("sp_busy",  32'(busy), 0);

      run_dump(4, 2, 2, 0, 0);
      run_dump(0, 2, 2, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
